// File: rtl/fir_mre_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mre_pkg
// Brief    : Shared types and widths for the FIR mean-relative-error monitor.
// Revision : 1.0
// ============================================================================
package mre_pkg;

    localparam int DATA_W = 16;
    localparam int ERR_W  = 17;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        DIV    = 2'd1,
        ACC    = 2'd2,
        FULL   = 2'd3
    } mre_state_t;

endpackage
`default_nettype wire

// File: rtl/fir_mre_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_mre_monitor_if
// Brief    : Sample-pair valid/ready handshake from the FIR pair to the monitor.
// Revision : 1.0
// ============================================================================
interface fir_mre_monitor_if;

    logic                                in_valid;
    logic                                in_ready;
    logic signed [mre_pkg::DATA_W-1:0]   y_apx;
    logic signed [mre_pkg::DATA_W-1:0]   y_ref;

    modport master (
        output in_valid,
        output y_apx,
        output y_ref,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  y_apx,
        input  y_ref,
        output in_ready
    );

endinterface
`default_nettype wire

// File: rtl/fir_mre_monitor_udiv.sv
`default_nettype none
// ============================================================================
// Module   : udiv_restoring_seq
// Brief    : Restoring unsigned divider, one quotient bit per cycle, MSB first.
// Revision : 1.0
// ============================================================================
module udiv_restoring_seq #(
    parameter int NUM_W = 25,
    parameter int DEN_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rstN,
    input  wire logic             abort,
    input  wire logic             load,
    input  wire logic [NUM_W-1:0] num,
    input  wire logic [DEN_W-1:0] den,
    output logic                  busy,
    output logic                  q_valid,
    output logic [NUM_W-1:0]      q
);

    localparam int STEP_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0]  r_quo;
    logic [DEN_W-1:0]  r_rem;
    logic [DEN_W-1:0]  r_den;
    logic [STEP_W-1:0] r_step;

    logic [DEN_W:0]    w_rem_sh;
    logic [DEN_W:0]    w_sub;
    logic              w_ge;
    logic [DEN_W-1:0]  w_rem_nxt;
    logic [NUM_W-1:0]  w_quo_nxt;

    // The remainder stays below den, so the shifted value never needs more than DEN_W+1 bits.
    assign w_rem_sh  = {r_rem, r_quo[NUM_W-1]};
    assign w_sub     = w_rem_sh - {1'b0, r_den};
    assign w_ge      = (w_rem_sh >= {1'b0, r_den});
    assign w_rem_nxt = w_ge ? w_sub[DEN_W-1:0] : w_rem_sh[DEN_W-1:0];
    assign w_quo_nxt = {r_quo[NUM_W-2:0], w_ge};

    assign busy    = (r_step != '0);
    assign q_valid = (r_step == STEP_W'(1));
    // On the final step the quotient is forwarded so it is usable in the strobe cycle.
    assign q       = q_valid ? w_quo_nxt : r_quo;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_den  <= '0;
            r_step <= '0;
        end else if (abort) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_den  <= '0;
            r_step <= '0;
        end else if (load) begin
            r_quo  <= num;
            r_rem  <= '0;
            r_den  <= den;
            r_step <= STEP_W'(NUM_W);
        end else if (busy) begin
            r_quo  <= w_quo_nxt;
            r_rem  <= w_rem_nxt;
            r_step <= r_step - STEP_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_mre_monitor.sv
`default_nettype none
// ============================================================================
// Module   : fir_mre_monitor
// Brief    : Windowed relative-error accumulator for the approximate-adder FIR.
// Revision : 1.0
// ============================================================================
module fir_mre_monitor
    import mre_pkg::*;
#(
    parameter int WINDOW = 256,
    parameter int FRAC   = 8,
    parameter int ACC_W  = 32
) (
    input  wire logic        clk,
    input  wire logic        rstN,
    input  wire logic        start,
    fir_mre_monitor_if.slave bus,
    output logic [ACC_W-1:0] sum_rel,
    output logic [15:0]      n_used,
    output logic [15:0]      n_zero,
    output logic             busy,
    output logic             done
);

    localparam int               Q_W       = ERR_W + FRAC;
    localparam int               SUM_W     = ((ACC_W > Q_W) ? ACC_W : Q_W) + 1;
    localparam logic [15:0]      c_window  = 16'(WINDOW);
    localparam logic [SUM_W-1:0] c_acc_max = (SUM_W'(1) << ACC_W) - SUM_W'(1);

    mre_state_t        r_state;
    logic [ACC_W-1:0]  r_sum;
    logic [15:0]       r_used;
    logic [15:0]       r_zero;
    logic [15:0]       r_cnt;
    logic              r_done;
    logic [Q_W-1:0]    r_q;

    logic              w_xfer;
    logic              w_ref_zero;
    logic              w_load;
    logic [ERR_W-1:0]  w_diff;
    logic [ERR_W-1:0]  w_err;
    logic [DATA_W-1:0] w_den;
    logic [Q_W-1:0]    w_num;
    logic [15:0]       w_cnt_nxt;
    logic              w_win_hit;
    logic [SUM_W-1:0]  w_sum_ext;
    logic [ACC_W-1:0]  w_sum_nxt;
    logic              w_div_busy;
    logic              w_div_q_valid;
    logic [Q_W-1:0]    w_div_q;

    assign bus.in_ready = (r_state == ACCEPT) & ~start;
    assign w_xfer       = bus.in_valid & bus.in_ready;
    assign w_ref_zero   = (bus.y_ref == '0);
    assign w_load       = w_xfer & ~w_ref_zero;

    // 17-bit difference cannot overflow; |-32768| lands on 0x8000 as an unsigned denominator.
    assign w_diff = {bus.y_apx[DATA_W-1], bus.y_apx} - {bus.y_ref[DATA_W-1], bus.y_ref};
    assign w_err  = w_diff[ERR_W-1] ? (-w_diff) : w_diff;
    assign w_den  = bus.y_ref[DATA_W-1] ? DATA_W'(-bus.y_ref) : DATA_W'(bus.y_ref);
    assign w_num  = Q_W'(w_err) << FRAC;

    assign w_cnt_nxt = r_cnt + 16'd1;
    assign w_win_hit = (w_cnt_nxt == c_window);

    assign w_sum_ext = SUM_W'(r_sum) + SUM_W'(r_q);
    assign w_sum_nxt = (w_sum_ext > c_acc_max) ? '1 : w_sum_ext[ACC_W-1:0];

    udiv_restoring_seq #(
        .NUM_W (Q_W),
        .DEN_W (DATA_W)
    ) u_div (
        .clk     (clk),
        .rstN    (rstN),
        .abort   (start),
        .load    (w_load),
        .num     (w_num),
        .den     (w_den),
        .busy    (w_div_busy),
        .q_valid (w_div_q_valid),
        .q       (w_div_q)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= ACCEPT;
            r_sum   <= '0;
            r_used  <= '0;
            r_zero  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_q     <= '0;
        end else if (start) begin
            r_state <= ACCEPT;
            r_sum   <= '0;
            r_used  <= '0;
            r_zero  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_q     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ACCEPT: begin
                    if (w_xfer) begin
                        if (w_ref_zero) begin
                            r_zero <= r_zero + 16'd1;
                            r_cnt  <= w_cnt_nxt;
                            if (w_win_hit) begin
                                r_state <= FULL;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_state <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (w_div_q_valid) begin
                        r_q     <= w_div_q;
                        r_state <= ACC;
                    end
                end
                ACC: begin
                    r_sum  <= w_sum_nxt;
                    r_used <= r_used + 16'd1;
                    r_cnt  <= w_cnt_nxt;
                    if (w_win_hit) begin
                        r_state <= FULL;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ACCEPT;
                    end
                end
                FULL: begin
                    r_state <= FULL;
                end
                default: begin
                    r_state <= ACCEPT;
                end
            endcase
        end
    end

    assign sum_rel = r_sum;
    assign n_used  = r_used;
    assign n_zero  = r_zero;
    // The divider is only active while in DIV, so this matches state DIV or ACC.
    assign busy    = w_div_busy | (r_state == ACC);
    assign done    = r_done;

endmodule
`default_nettype wire
